glb_core_strm_rd_switch: RTL and testbench

- Read-path stream switch for one global buffer tile. It consumes the read-request and read-response stream that the tile's stream router hands to the core (sr2sw), and produces the return stream (sw2sr).
- Ring read requests that hit this tile are issued to the local bank; misses are forwarded.
- Bank read data is merged into the outgoing response stream. Pass-through ring responses have priority, and bank responses wait in a small FIFO.

---
 rtl/glb_core_strm_rd_switch_pkg.sv | 20 ++
 rtl/glb_rsp_fifo.sv | 62 ++++++
 rtl/glb_core_strm_rd_switch.sv | 118 +++++++++++
 tb/tb_glb_core_strm_rd_switch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_core_strm_rd_switch_pkg.sv
// rtl/glb_core_strm_rd_switch_pkg.sv - global buffer widths and read-path packet types
package glb_core_strm_rd_switch_pkg;
  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int TILE_SEL_ADDR_WIDTH = 4;
  localparam int BANK_SEL_ADDR_WIDTH = 1;
  localparam int BANK_ADDR_WIDTH     = 17;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int BANK_RD_LATENCY     = 2;
  localparam int RSP_FIFO_DEPTH      = 4;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic                       rd_data_valid;
    logic [BANK_DATA_WIDTH-1:0] rd_data;
  } rdrs_packet_t;
endpackage

// File: rtl/glb_rsp_fifo.sv
// rtl/glb_rsp_fifo.sv - synchronous response FIFO with clock-enable hold
module glb_rsp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];
  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clk_en) begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/glb_core_strm_rd_switch.sv
// rtl/glb_core_strm_rd_switch.sv - tile read switch: local bank hits, ring forwarding, response merge
module glb_core_strm_rd_switch
  import glb_core_strm_rd_switch_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
  input  logic                           cfg_rd_switch_en,
  input  logic                           cfg_err_clr,
  input  logic                           rdrq_sr2sw_en,
  input  logic [GLB_ADDR_WIDTH-1:0]      rdrq_sr2sw_addr,
  output logic                           rdrq_sw2sr_en,
  output logic [GLB_ADDR_WIDTH-1:0]      rdrq_sw2sr_addr,
  output logic                           bank_rd_en,
  output logic [BANK_SEL_ADDR_WIDTH-1:0] bank_rd_sel,
  output logic [BANK_ADDR_WIDTH-1:0]     bank_rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0]     bank_rd_data,
  input  logic                           rdrs_sr2sw_valid,
  input  logic [BANK_DATA_WIDTH-1:0]     rdrs_sr2sw_data,
  output logic                           rdrs_sw2sr_valid,
  output logic [BANK_DATA_WIDTH-1:0]     rdrs_sw2sr_data,
  output logic                           err_rsp_overflow
);
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  logic [TILE_SEL_ADDR_WIDTH-1:0] rq_tile;
  logic [BANK_SEL_ADDR_WIDTH-1:0] rq_bank;
  logic [BANK_ADDR_WIDTH-1:0]     rq_offset;
  logic                           hit, miss;

  rdrq_packet_t               fwd_q, fwd_d;
  rdrs_packet_t               rsp_q, rsp_d;
  logic [BANK_RD_LATENCY-1:0] vld_q, vld_d;
  logic                       err_q, err_d;

  logic                       bank_vld, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BANK_DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]           fifo_count_unused;

  assign rq_tile   = rdrq_sr2sw_addr[BANK_ADDR_WIDTH+BANK_SEL_ADDR_WIDTH +: TILE_SEL_ADDR_WIDTH];
  assign rq_bank   = rdrq_sr2sw_addr[BANK_ADDR_WIDTH +: BANK_SEL_ADDR_WIDTH];
  assign rq_offset = rdrq_sr2sw_addr[BANK_ADDR_WIDTH-1:0];
  assign hit       = rdrq_sr2sw_en & cfg_rd_switch_en & (rq_tile == glb_tile_id);
  assign miss      = rdrq_sr2sw_en & ~hit;

  assign bank_rd_en   = hit & clk_en & ~reset;
  assign bank_rd_sel  = bank_rd_en ? rq_bank : '0;
  assign bank_rd_addr = bank_rd_en ? rq_offset : '0;
  assign bank_vld     = vld_q[BANK_RD_LATENCY-1];

  assign rdrq_sw2sr_en    = fwd_q.rd_en;
  assign rdrq_sw2sr_addr  = fwd_q.rd_addr;
  assign rdrs_sw2sr_valid = rsp_q.rd_data_valid;
  assign rdrs_sw2sr_data  = rsp_q.rd_data;
  assign err_rsp_overflow = err_q;

  always_comb begin
    fwd_d     = fwd_q;
    rsp_d     = rsp_q;
    vld_d     = vld_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (clk_en) begin
      fwd_d.rd_en   = miss;
      fwd_d.rd_addr = miss ? rdrq_sr2sw_addr : '0;
      vld_d         = BANK_RD_LATENCY'({vld_q, bank_rd_en});
      // Ring traffic owns the output; bank data only bypasses the FIFO when nothing is queued ahead of it.
      if (rdrs_sr2sw_valid) begin
        rsp_d.rd_data_valid = 1'b1;
        rsp_d.rd_data       = rdrs_sr2sw_data;
        fifo_push           = bank_vld;
      end else if (!fifo_empty) begin
        rsp_d.rd_data_valid = 1'b1;
        rsp_d.rd_data       = fifo_head;
        fifo_pop            = 1'b1;
        fifo_push           = bank_vld;
      end else if (bank_vld) begin
        rsp_d.rd_data_valid = 1'b1;
        rsp_d.rd_data       = bank_rd_data;
      end else begin
        rsp_d.rd_data_valid = 1'b0;
      end
      err_d = (fifo_push & fifo_full & ~fifo_pop) | (err_q & ~cfg_err_clr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_q <= '0;
      rsp_q <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      fwd_q <= fwd_d;
      rsp_q <= rsp_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  glb_rsp_fifo #(
    .WIDTH(BANK_DATA_WIDTH),
    .DEPTH(RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .push      (fifo_push),
    .push_data (bank_rd_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );
endmodule

// File: tb/tb_glb_core_strm_rd_switch.sv
// tb/tb_glb_core_strm_rd_switch.sv - directed and random bench with a queue-based reference model
module tb_glb_core_strm_rd_switch;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int          age;
    logic [63:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset, clk_en, cfg_en, err_clr, req_en, rs_valid;
  logic [3:0]  tile_id;
  logic [21:0] req_addr;
  logic [63:0] bank_data, rs_data;
  logic        fwd_en, bank_rd_en, rsp_valid, err_ovf;
  logic [21:0] fwd_addr;
  logic [0:0]  bank_rd_sel;
  logic [16:0] bank_rd_addr;
  logic [63:0] rsp_data;

  always #5 clk = ~clk;

  glb_core_strm_rd_switch dut (
    .clk              (clk),
    .reset            (reset),
    .clk_en           (clk_en),
    .glb_tile_id      (tile_id),
    .cfg_rd_switch_en (cfg_en),
    .cfg_err_clr      (err_clr),
    .rdrq_sr2sw_en    (req_en),
    .rdrq_sr2sw_addr  (req_addr),
    .rdrq_sw2sr_en    (fwd_en),
    .rdrq_sw2sr_addr  (fwd_addr),
    .bank_rd_en       (bank_rd_en),
    .bank_rd_sel      (bank_rd_sel),
    .bank_rd_addr     (bank_rd_addr),
    .bank_rd_data     (bank_data),
    .rdrs_sr2sw_valid (rs_valid),
    .rdrs_sr2sw_data  (rs_data),
    .rdrs_sw2sr_valid (rsp_valid),
    .rdrs_sw2sr_data  (rsp_data),
    .err_rsp_overflow (err_ovf)
  );

  int          n_chk = 0;
  int          n_err = 0;
  rd_t         pend[$];
  logic [63:0] fifo_q[$];
  logic [63:0] mem [logic [17:0]];
  logic [63:0] obs_q[$];
  logic        m_vld, m_err, m_fwd_en;
  logic [63:0] m_dat;
  logic [21:0] m_fwd_addr;
  logic        last_bank_en;
  logic [0:0]  last_sel;
  logic [16:0] last_addr;
  int          nseen;

  function automatic logic [63:0] bank_word(input logic [17:0] key);
    if (mem.exists(key)) return mem[key];
    return {14'h2a5, 32'hc0de_0000, key};
  endfunction

  function automatic logic model_hit();
    return req_en & cfg_en & (req_addr[21:18] == tile_id);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fifo_q.delete();
    m_vld = 0; m_dat = '0; m_err = 0; m_fwd_en = 0; m_fwd_addr = '0;
  endtask

  task automatic model_edge();
    logic dv, ovf, h;
    logic [63:0] dd;
    h   = model_hit();
    dv  = (pend.size() > 0) && (pend[0].age == LAT);
    dd  = dv ? pend[0].data : '0;
    ovf = 0;
    if (rs_valid) begin
      m_vld = 1; m_dat = rs_data;
      if (dv) begin
        if (fifo_q.size() == DEPTH) ovf = 1;
        else fifo_q.push_back(dd);
      end
    end else if (fifo_q.size() > 0) begin
      m_vld = 1; m_dat = fifo_q.pop_front();
      if (dv) fifo_q.push_back(dd);
    end else if (dv) begin
      m_vld = 1; m_dat = dd;
    end else begin
      m_vld = 0;
    end
    if (ovf) m_err = 1;
    else if (err_clr) m_err = 0;
    m_fwd_en   = req_en & ~h;
    m_fwd_addr = m_fwd_en ? req_addr : '0;
    if (dv) pend.delete(0);
    foreach (pend[i]) pend[i].age++;
    if (h) pend.push_back('{1, bank_word(req_addr[17:0])});
  endtask

  task automatic step();
    logic exp_en;
    if (pend.size() > 0 && pend[0].age == LAT) bank_data = pend[0].data;
    else bank_data = {$urandom, $urandom};
    #4;
    exp_en       = clk_en & ~reset & model_hit();
    last_bank_en = bank_rd_en;
    last_sel     = bank_rd_sel;
    last_addr    = bank_rd_addr;
    chk("bank_rd_en", bank_rd_en, exp_en);
    if (exp_en) begin
      chk("bank_rd_sel", bank_rd_sel, req_addr[17]);
      chk("bank_rd_addr", bank_rd_addr, req_addr[16:0]);
    end
    chk("fwd_en", fwd_en, m_fwd_en);
    chk("fwd_addr", fwd_addr, m_fwd_addr);
    chk("rsp_valid", rsp_valid, m_vld);
    chk("rsp_data", rsp_data, m_dat);
    chk("err_ovf", err_ovf, m_err);
    @(posedge clk);
    if (reset) model_reset();
    else if (clk_en) model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    req_en = 0; rs_valid = 0; err_clr = 0;
    repeat (n) step();
  endtask

  initial begin
    reset = 1; clk_en = 1; cfg_en = 1; err_clr = 0; req_en = 0; rs_valid = 0;
    tile_id = 4'd3; req_addr = '0; rs_data = '0; bank_data = '0;
    model_reset();
    mem[{1'b1, 17'h40}] = 64'hDEAD;
    for (int i = 0; i < 3; i++) mem[{1'b0, 17'(i + 1)}] = 64'hB1 + 64'(i);
    @(posedge clk); #1;
    step();
    reset = 0;
    idle(2);

    // Hit with idle ring: same-cycle bank strobe, response LAT+1 cycles later.
    req_en = 1; req_addr = {4'd3, 1'b1, 17'h40};
    step();
    chk("hit_bank_en", last_bank_en, 1);
    chk("hit_bank_sel", last_sel, 1);
    chk("hit_bank_addr", last_addr, 17'h40);
    req_en = 0;
    step(); step();
    chk("hit_rsp_valid", rsp_valid, 1);
    chk("hit_rsp_data", rsp_data, 64'hDEAD);
    idle(2);

    // Misses: foreign tile, then own tile with the switch disabled.
    req_en = 1; req_addr = {4'd5, 1'b0, 17'h123};
    step();
    chk("miss_no_bank", last_bank_en, 0);
    chk("miss_fwd_en", fwd_en, 1);
    chk("miss_fwd_addr", fwd_addr, {4'd5, 1'b0, 17'h123});
    cfg_en = 0; req_addr = {4'd3, 1'b1, 17'h55};
    step();
    chk("off_no_bank", last_bank_en, 0);
    chk("off_fwd_en", fwd_en, 1);
    chk("off_fwd_addr", fwd_addr, {4'd3, 1'b1, 17'h55});
    cfg_en = 1;
    idle(3);

    // Collision: ring words first, then queued bank words in issue order.
    obs_q.delete();
    for (int i = 0; i < 14; i++) begin
      rs_valid = (i < 6); rs_data = 64'hA000 + 64'(i);
      req_en = (i < 3); req_addr = {tile_id, 1'b0, 17'(i + 1)};
      step();
      if (rsp_valid) obs_q.push_back(rsp_data);
    end
    chk("col_count", obs_q.size(), 9);
    for (int i = 0; i < 9 && i < obs_q.size(); i++)
      chk("col_word", obs_q[i], (i < 6) ? 64'hA000 + 64'(i) : 64'hB1 + 64'(i - 6));
    chk("col_no_err", err_ovf, 0);
    idle(2);

    // Overflow: six hits against a busy ring, four survive.
    for (int i = 0; i < 10; i++) begin
      rs_valid = 1; rs_data = {$urandom, $urandom};
      req_en = (i < 6); req_addr = {tile_id, 1'b0, 17'(16 + i)};
      step();
    end
    chk("ovf_set", err_ovf, 1);
    req_en = 0; rs_valid = 0; obs_q.delete();
    repeat (8) begin
      step();
      if (rsp_valid) obs_q.push_back(rsp_data);
    end
    chk("ovf_kept", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk("ovf_word", obs_q[i], bank_word({1'b0, 17'(16 + i)}));
    chk("ovf_sticky", err_ovf, 1);
    err_clr = 1; step(); err_clr = 0;
    chk("ovf_clr", err_ovf, 0);
    idle(2);

    // clk_en low for three cycles mid-stream.
    for (int i = 0; i < 12; i++) begin
      req_en = (i < 5); req_addr = {tile_id, 1'(i), 17'(i + 'h100)};
      clk_en = !(i >= 3 && i < 6);
      step();
      if (i >= 3 && i < 6) chk("pause_no_bank", last_bank_en, 0);
    end
    clk_en = 1;
    idle(3);

    // Asynchronous reset one cycle after a hit.
    req_en = 1; req_addr = {tile_id, 1'b1, 17'h77};
    step();
    req_en = 0; reset = 1;
    #1;
    chk("rst_bank_en", bank_rd_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_fwd_en", fwd_en, 0);
    chk("rst_err", err_ovf, 0);
    model_reset();
    step();
    reset = 0; nseen = 0;
    repeat (6) begin
      step();
      if (rsp_valid) nseen++;
    end
    chk("rst_no_stray", nseen, 0);

    // Random traffic against the reference model.
    tile_id = 4'($urandom_range(15));
    for (int i = 0; i < 400; i++) begin
      clk_en   = ($urandom_range(9) != 0);
      cfg_en   = ($urandom_range(15) != 0);
      req_en   = 1'($urandom_range(1));
      req_addr = {($urandom_range(1) != 0) ? tile_id : 4'($urandom), 18'($urandom)};
      rs_valid = ((i % 40) < 20) ? ($urandom_range(3) != 0) : ($urandom_range(4) == 0);
      rs_data  = {$urandom, $urandom};
      err_clr  = ($urandom_range(19) == 0);
      step();
    end
    clk_en = 1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
